// File: rtl/jrb8_input_port_if.sv
// ---------------------------------------------------------------------------
// jrb8_input_port_if
//
// Bundles the switch input, CPU read handshake and status outputs of the
// jrb8 input port. Clock and reset stay outside the interface.
//
// Signals:
//   ena      - design enable (low freezes debounce state and holding reg)
//   sw_in    - raw switch inputs, asynchronous to clk
//   rd_req   - one-cycle CPU read strobe
//   rd_data  - holding register contents
//   rd_valid - holding register contains an unread byte
//   overrun  - sticky: an unread byte was overwritten
//   level    - current settled switch value
//
// Modports:
//   master - CPU / stimulus side (drives ena, sw_in, rd_req)
//   slave  - the input port itself
// ---------------------------------------------------------------------------
interface jrb8_input_port_if;
    logic       ena;
    logic [7:0] sw_in;
    logic       rd_req;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       overrun;
    logic [7:0] level;

    modport master (
        output ena,
        output sw_in,
        output rd_req,
        input  rd_data,
        input  rd_valid,
        input  overrun,
        input  level
    );

    modport slave (
        input  ena,
        input  sw_in,
        input  rd_req,
        output rd_data,
        output rd_valid,
        output overrun,
        output level
    );
endinterface

// File: rtl/jrb8_input_port.sv
// ---------------------------------------------------------------------------
// jrb8_input_port
//
// Input side of the jrb8 computer: synchronises the eight switches,
// debounces them and hands each newly settled byte to the CPU through a
// one-entry holding register with a valid/read handshake. The settled value
// is also exposed continuously on `level` for polling.
//
// Optional feature macro: JRB8_INPUT_DEBOUNCE_EN
//   defined   - two-state debounce FSM (STABLE/SETTLING) with a 24-bit
//               counter; a value must hold DEBOUNCE_CYCLES cycles before it
//               is committed.
//   undefined - no debounce: any synchronised change is committed on the
//               next enabled edge; DEBOUNCE_CYCLES is ignored.
//
// Parameters:
//   DEBOUNCE_CYCLES - cycles the synchronised input must hold (1..2^24-1)
//
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - jrb8_input_port_if.slave (ena, sw_in, rd_req in;
//           rd_data, rd_valid, overrun, level out)
//
// All outputs are registered; no combinational path from sw_in or rd_req.
// ---------------------------------------------------------------------------
module jrb8_input_port #(
    parameter logic [23:0] DEBOUNCE_CYCLES = 24'd10_000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    jrb8_input_port_if.slave         bus
);

    // -----------------------------------------------------------------------
    // Two-flop synchroniser; runs regardless of ena.
    // -----------------------------------------------------------------------
    logic [7:0] s1_q;
    logic [7:0] s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= bus.sw_in;
            s2_q <= s1_q;
        end
    end

    // -----------------------------------------------------------------------
    // Output registers
    // -----------------------------------------------------------------------
    logic [7:0] level_q,    level_d;
    logic [7:0] rd_data_q,  rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic       overrun_q,  overrun_d;

    // Commit request from the debounce stage and the byte it carries.
    logic       commit;
    logic [7:0] commit_data;

`ifdef JRB8_INPUT_DEBOUNCE_EN
    // -----------------------------------------------------------------------
    // Debounce FSM
    // -----------------------------------------------------------------------
    typedef enum logic {
        ST_STABLE,
        ST_SETTLING
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cand_q,  cand_d;
    logic [23:0] cnt_q,   cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STABLE;
            cand_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        commit      = 1'b0;
        commit_data = cand_q;

        if (bus.ena) begin
            unique case (state_q)
                ST_STABLE: begin
                    if (s2_q != level_q) begin
                        state_d = ST_SETTLING;
                        cand_d  = s2_q;
                        cnt_d   = '0;
                    end
                end
                ST_SETTLING: begin
                    if (s2_q != cand_q) begin
                        // Any bounce restarts the settling window.
                        cand_d = s2_q;
                        cnt_d  = '0;
                    end else if (cnt_q == DEBOUNCE_CYCLES - 24'd1) begin
                        state_d = ST_STABLE;
                        // Input settled back on the old value: nothing new
                        // to present.
                        commit  = (cand_q != level_q);
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
                default: begin
                    state_d = ST_STABLE;
                end
            endcase
        end
    end
`else
    // -----------------------------------------------------------------------
    // No debounce: any synchronised change commits on an enabled edge.
    // -----------------------------------------------------------------------
    always_comb begin
        commit      = bus.ena && (s2_q != level_q);
        commit_data = s2_q;
    end

    // The parameter has no role in this build.
    logic unused_debounce_cycles;
    assign unused_debounce_cycles = ^DEBOUNCE_CYCLES;
`endif

    // -----------------------------------------------------------------------
    // Holding register and handshake
    // -----------------------------------------------------------------------
    logic rd_fire;

    always_comb begin
        rd_fire    = bus.ena && bus.rd_req && rd_valid_q;

        level_d    = level_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        overrun_d  = overrun_q;

        if (commit) begin
            level_d    = commit_data;
            rd_data_d  = commit_data;
            rd_valid_d = 1'b1;
        end else if (rd_fire) begin
            rd_valid_d = 1'b0;
        end

        // A read on the commit edge consumes the old byte, so it is not lost.
        if (rd_fire) begin
            overrun_d = 1'b0;
        end else if (commit && rd_valid_q) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            level_q    <= level_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.level    = level_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.overrun  = overrun_q;

endmodule

// File: doc/jrb8_input_port.md
# jrb8_input_port

Input-side counterpart of the seven-segment output path in the jrb8 computer top level. Synchronises the eight input switches (`ui_in`), debounces them, and presents each newly settled byte to the CPU through a one-entry holding register with a valid/read handshake. The CPU's IN instruction reads through this block, and the raw settled level stays visible for polling.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default `24'd10_000`: number of consecutive cycles the synchronised input must hold before it is accepted. Legal range is 1 to 2^24−1.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `ena`, input, 1: design enable. While low, the debounce counter and the holding register freeze.
- `sw_in`, input, 8: raw switch inputs, asynchronous to `clk`.
- `rd_req`, input, 1: CPU read strobe, one cycle wide, sampled on the rising edge of `clk`.
- `rd_data`, output, 8: holding register contents.
- `rd_valid`, output, 1: the holding register contains an unread byte.
- `overrun`, output, 1: sticky flag. Set when an unread byte was overwritten.
- `level`, output, 8: current debounced (settled) value.

## Operation

- Reset values: `rd_data`, `rd_valid`, `overrun`, `level`, both synchroniser stages, the candidate register and the counter are all 0. The FSM starts in STABLE.
- Synchroniser: two flops on `sw_in`, named `s1` and `s2`. They run whenever reset is deasserted, regardless of `ena`.
- Debounce FSM. The states are STABLE and SETTLING; the counter `cnt` is 24 bits.
  - In STABLE, if `s2 != level`: go to SETTLING, set `cand <= s2`, set `cnt <= 0`.
  - In SETTLING, if `s2 != cand`: set `cand <= s2`, set `cnt <= 0`, and stay in SETTLING. This restarts settling on any bounce.
  - In SETTLING, if `s2 == cand` and `cnt == DEBOUNCE_CYCLES-1`: commit, then go to STABLE.
  - In SETTLING, if `s2 == cand` otherwise: `cnt <= cnt+1`.
  - If `cand` equals `level` at commit time (the input bounced back to the old value): update nothing and go to STABLE. No `rd_valid` is produced.
- Commit: `level <= cand` and `rd_data <= cand`, and `rd_valid` is set to 1. If `rd_valid` was already 1 and no read occurs in the same cycle, `overrun` is set to 1.
- Read: a cycle with `rd_req=1` and `rd_valid=1` clears `rd_valid` and `overrun` on that edge. `rd_req` while `rd_valid=0` has no effect.
- Commit and read in the same cycle: the new byte is loaded, `rd_valid` stays 1, and `overrun` is cleared, not set.
- `ena=0`: the FSM, `cnt`, `level`, `rd_data`, `rd_valid` and `overrun` all hold. Reads are ignored.
- Counter width: 24 bits. It never wraps, because it resets before reaching `DEBOUNCE_CYCLES`.

## Timing

- Let `sw_in` change before rising edge E0 and then stay steady.
  - `s1` updates at E0 and `s2` at E1.
  - The FSM enters SETTLING at E2.
  - Commit happens at edge E(2+`DEBOUNCE_CYCLES`), and `rd_valid`, `rd_data` and `level` change right after it.
  - Total latency is `DEBOUNCE_CYCLES`+3 edges, counting E0.
- Read latency: `rd_valid` falls on the same edge that samples `rd_req`.
- `rd_data` is stable from commit until the next commit. It is not cleared by a read.
- All outputs are registered. There is no combinational path from `rd_req` or `sw_in` to any output.
- Asynchronous reset in the middle of SETTLING returns the block to its reset state immediately. After reset release, an input that is still nonzero is re-debounced from scratch.

## Configuration

- Macro: `JRB8_INPUT_DEBOUNCE_EN`.
- Defined: behaviour is as described above.
- Undefined:
  - The FSM, `cand` and `cnt` are removed, and `DEBOUNCE_CYCLES` is ignored.
  - Commit occurs at any edge where `s2 != level` and `ena=1`.
  - Latency is 3 edges (E0 to E2).
  - Handshake and `overrun` rules are unchanged.

## Test plan

All scenarios use `DEBOUNCE_CYCLES=4` with the macro defined unless stated.

1. Reset, then drive `sw_in=0xA5` and hold → `rd_valid=1`, `rd_data=0xA5`, `level=0xA5` exactly 7 edges after the change. Pulse `rd_req` → `rd_valid=0` on the next edge, `rd_data` still `0xA5`.
2. Toggle `sw_in` 0x00↔0x01 every 2 cycles for 20 cycles, then hold at 0x01 → no commit during the toggling. A single commit of 0x01 occurs 7 edges after the final change.
3. Commit 0x11 and do not read, then commit 0x22 → `rd_data=0x22`, `overrun=1`. A read clears both `rd_valid` and `overrun`.
4. Assert `rd_req` on the exact commit edge of 0x33 while 0x22 is unread → `rd_valid=1`, `rd_data=0x33`, `overrun=0`.
5. Drop `ena` during SETTLING for 10 cycles → no commit. After `ena` returns, commit follows after the remaining count. Pull `rst_n` low mid-SETTLING → all outputs go to 0 immediately.
6. With the macro undefined, change `sw_in` to 0x5A → commit after 3 edges. Glitch pulses one cycle wide are each committed, and `overrun` is set if they are not read.
